// File: rtl/platform_pkg.sv
// Shared constants, FSM state type and platform position payload for the
// platform field block and its LFSR.
package platform_pkg;

   // Default screen and field geometry
   localparam int unsigned DEF_NUM_PLAT    = 8;
   localparam int unsigned DEF_SCREEN_W    = 640;
   localparam int unsigned DEF_SCREEN_H    = 480;
   localparam int unsigned DEF_PLAT_W      = 64;
   localparam int unsigned DEF_SPACING     = 60;
   localparam int unsigned DEF_SCROLL_LINE = 160;
   localparam int unsigned DEF_MAX_STEP    = 32;

   // Datapath widths
   localparam int unsigned X_W     = 10;
   localparam int unsigned Y_W     = 11;
   localparam int unsigned STEP_W  = 8;
   localparam int unsigned SCORE_W = 20;
   localparam int unsigned LFSR_W  = 16;

   // 16-bit Fibonacci LFSR: taps 16,14,13,11 map to bits 15,13,12,10
   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CALC    = 3'd1,
      ST_SCROLL  = 3'd2,
      ST_RECYCLE = 3'd3,
      ST_DONE    = 3'd4
   } fsm_state_t;

   typedef struct packed {
      logic        [X_W-1:0] x;
      logic signed [Y_W-1:0] y;
   } plat_pos_t;

   // Fold a 10-bit random value into 0..range-1 (range lies in 512..1023)
   function automatic logic [X_W-1:0] fold_rnd(input logic [X_W-1:0] r,
                                               input logic [X_W-1:0] range);
      return (r < range) ? r : (r - range);
   endfunction

endpackage

// File: rtl/platform_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used for platform respawn x positions.
// Ports:
//   Clk     - system clock
//   Reset_n - asynchronous active-low reset (loads the seed)
//   lfsr    - current LFSR state
module platform_lfsr
   import platform_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset_n,
   output logic [LFSR_W-1:0] lfsr
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   // Shift left, feedback is XOR of the tapped bits
   always_comb begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/platform_field.sv
// Platform manager: scrolls the platform field while the doodle rises above
// the scroll line and respawns platforms that fall off the bottom. Consumers
// see a snapshot that updates atomically once per frame.
// Optional feature: define PLATFORM_SCORE_EN to build the score accumulator.
// Ports:
//   Clk, Reset_n  - clock, asynchronous active-low reset
//   Frame_Clk     - one-cycle frame-start pulse
//   doodle_y      - doodle top y (screen coordinates)
//   doodle_up     - doodle moving upward
//   plat_x        - snapshot x per platform, 10 bits each
//   plat_y        - snapshot y per platform, 11-bit signed each
//   scroll_step   - pixels scrolled in the last frame
//   frame_done    - one-cycle pulse, snapshot updates at the end of it
//   busy          - FSM not idle
//   overrun       - sticky, Frame_Clk seen while busy
//   score         - accumulated scroll (0 unless PLATFORM_SCORE_EN)
module platform_field
   import platform_pkg::*;
#(
   parameter int unsigned NUM_PLAT    = DEF_NUM_PLAT,
   parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H    = DEF_SCREEN_H,
   parameter int unsigned PLAT_W      = DEF_PLAT_W,
   parameter int unsigned SPACING     = DEF_SPACING,
   parameter int unsigned SCROLL_LINE = DEF_SCROLL_LINE,
   parameter int unsigned MAX_STEP    = DEF_MAX_STEP
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      Frame_Clk,
   input  logic [X_W-1:0]            doodle_y,
   input  logic                      doodle_up,
   output logic [NUM_PLAT*X_W-1:0]   plat_x,
   output logic [NUM_PLAT*Y_W-1:0]   plat_y,
   output logic [STEP_W-1:0]         scroll_step,
   output logic                      frame_done,
   output logic                      busy,
   output logic                      overrun,
   output logic [SCORE_W-1:0]        score
);

   localparam int unsigned IDX_W = $clog2(NUM_PLAT);
   localparam int unsigned RANGE = SCREEN_W - PLAT_W;

   // Power-on / reset layout of a platform
   function automatic plat_pos_t init_pos(input int unsigned i);
      plat_pos_t p;
      p.x = (i == 0) ? X_W'(RANGE / 2) : X_W'((i * 32'd137) % RANGE);
      p.y = Y_W'(SCREEN_H - 32'd20 - i * SPACING);
      return p;
   endfunction

   fsm_state_t             state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [STEP_W-1:0]      step_q, step_d;
   logic signed [Y_W-1:0]  top_q, top_d;
   logic [X_W-1:0]         dy_q, dy_d;
   logic                   dup_q, dup_d;
   plat_pos_t              work_q [NUM_PLAT];
   plat_pos_t              work_d [NUM_PLAT];
   plat_pos_t              snap_q [NUM_PLAT];
   plat_pos_t              snap_d [NUM_PLAT];
   logic [STEP_W-1:0]      scroll_step_q, scroll_step_d;
   logic                   frame_done_q, frame_done_d;
   logic                   busy_q, busy_d;
   logic                   overrun_q, overrun_d;

   logic [LFSR_W-1:0]      lfsr_c;
   logic                   lfsr_unused_c;
   logic [X_W-1:0]         rnd_c;
   logic [X_W-1:0]         diff_c;
   logic [STEP_W-1:0]      step_c;
   logic signed [Y_W-1:0]  y_add_c;
   logic signed [Y_W-1:0]  respawn_y_c;
   logic                   last_idx_c;

   platform_lfsr u_lfsr (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .lfsr    (lfsr_c)
   );

   // Only the low 10 bits feed the respawn position
   assign lfsr_unused_c = |lfsr_c[LFSR_W-1:X_W];
   assign rnd_c         = fold_rnd(lfsr_c[X_W-1:0], X_W'(RANGE));

   // Per-frame scroll step from the latched doodle state
   always_comb begin
      diff_c = '0;
      if (dup_q && (dy_q < X_W'(SCROLL_LINE))) begin
         diff_c = X_W'(SCROLL_LINE) - dy_q;
      end
      step_c = (diff_c > X_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : STEP_W'(diff_c);
   end

   assign y_add_c     = work_q[idx_q].y + $signed(Y_W'(step_q));
   assign respawn_y_c = top_q - $signed(Y_W'(SPACING));
   assign last_idx_c  = (idx_q == IDX_W'(NUM_PLAT - 1));

   // Next-state and datapath
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      step_d        = step_q;
      top_d         = top_q;
      dy_d          = dy_q;
      dup_d         = dup_q;
      work_d        = work_q;
      snap_d        = snap_q;
      scroll_step_d = scroll_step_q;
      frame_done_d  = 1'b0;
      overrun_d     = overrun_q | (Frame_Clk && (state_q != ST_IDLE));

      case (state_q)
         ST_IDLE: begin
            if (Frame_Clk) begin
               dy_d    = doodle_y;
               dup_d   = doodle_up;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            step_d = step_c;
            idx_d  = '0;
            if (step_c == '0) begin
               state_d      = ST_DONE;
               frame_done_d = 1'b1;
            end else begin
               top_d   = 11'sd1023;
               state_d = ST_SCROLL;
            end
         end
         ST_SCROLL: begin
            work_d[idx_q].y = y_add_c;
            // Track the topmost platform still on screen
            if ((y_add_c < $signed(Y_W'(SCREEN_H))) && (y_add_c < top_q)) begin
               top_d = y_add_c;
            end
            if (last_idx_c) begin
               idx_d   = '0;
               state_d = ST_RECYCLE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_RECYCLE: begin
            // Respawned platforms stack upward from the current top
            if (work_q[idx_q].y >= $signed(Y_W'(SCREEN_H))) begin
               work_d[idx_q].y = respawn_y_c;
               work_d[idx_q].x = rnd_c;
               top_d           = respawn_y_c;
            end
            if (last_idx_c) begin
               idx_d        = '0;
               state_d      = ST_DONE;
               frame_done_d = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DONE: begin
            snap_d        = work_q;
            scroll_step_d = step_q;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         step_q        <= '0;
         top_q         <= '0;
         dy_q          <= '0;
         dup_q         <= 1'b0;
         scroll_step_q <= '0;
         frame_done_q  <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
         for (int i = 0; i < int'(NUM_PLAT); i++) begin
            work_q[i] <= init_pos(unsigned'(i));
            snap_q[i] <= init_pos(unsigned'(i));
         end
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         step_q        <= step_d;
         top_q         <= top_d;
         dy_q          <= dy_d;
         dup_q         <= dup_d;
         scroll_step_q <= scroll_step_d;
         frame_done_q  <= frame_done_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
         work_q        <= work_d;
         snap_q        <= snap_d;
      end
   end

   // Flatten the snapshot onto the output buses
   for (genvar g = 0; g < int'(NUM_PLAT); g++) begin : g_out
      assign plat_x[g*X_W +: X_W] = snap_q[g].x;
      assign plat_y[g*Y_W +: Y_W] = snap_q[g].y;
   end

   assign scroll_step = scroll_step_q;
   assign frame_done  = frame_done_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;

`ifdef PLATFORM_SCORE_EN
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W:0]   score_sum_c;

   // Saturating accumulation of the scroll step on the DONE edge
   always_comb begin
      score_sum_c = {1'b0, score_q} + (SCORE_W + 1)'(step_q);
      score_d     = score_q;
      if (state_q == ST_DONE) begin
         score_d = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score = score_q;
`else
   assign score = '0;
`endif

endmodule

// File: tb/tb_platform_field.sv
// Directed self-checking bench for platform_field with default parameters.
module tb_platform_field;

   logic        Clk;
   logic        Reset_n;
   logic        Frame_Clk;
   logic [9:0]  doodle_y;
   logic        doodle_up;
   logic [79:0] plat_x;
   logic [87:0] plat_y;
   logic [7:0]  scroll_step;
   logic        frame_done;
   logic        busy;
   logic        overrun;
   logic [19:0] score;

   int checks;
   int failures;
   int exp_y [8];
   int exp_score;

   platform_field dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .Frame_Clk   (Frame_Clk),
      .doodle_y    (doodle_y),
      .doodle_up   (doodle_up),
      .plat_x      (plat_x),
      .plat_y      (plat_y),
      .scroll_step (scroll_step),
      .frame_done  (frame_done),
      .busy        (busy),
      .overrun     (overrun),
      .score       (score)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_ys(input string tag);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_y%0d", tag, i), 32'(plat_y[i*11 +: 11]), 32'(exp_y[i]));
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Start a frame, optionally re-pulse Frame_Clk mid-frame, check latency and result
   task automatic run_frame(input logic [9:0] dy, input logic up, input int exp_lat,
                            input int inject_at, input int exp_step);
      int n;
      doodle_y  = dy;
      doodle_up = up;
      Frame_Clk = 1'b1;
      tick();
      Frame_Clk = 1'b0;
      check("busy_calc", 32'(busy), 32'd1);
      n = 0;
      while (frame_done !== 1'b1 && n < 100) begin
         if (n == inject_at) Frame_Clk = 1'b1;
         tick();
         Frame_Clk = 1'b0;
         n++;
      end
      check("latency", 32'(n), 32'(exp_lat));
      tick();
      check("frame_done_pulse", 32'(frame_done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("scroll_step", 32'(scroll_step), 32'(exp_step));
`ifdef PLATFORM_SCORE_EN
      exp_score += exp_step;
`endif
      check("score", 32'(score), 32'(exp_score));
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      exp_score = 0;
      Reset_n   = 1'b0;
      Frame_Clk = 1'b0;
      doodle_y  = 10'd300;
      doodle_up = 1'b0;
      repeat (3) tick();
      Reset_n = 1'b1;
      tick();

      // Reset state
      exp_y = '{460, 400, 340, 280, 220, 160, 100, 40};
      check_ys("reset");
      check("reset_x0", 32'(plat_x[9:0]), 32'd288);
      check("reset_x1", 32'(plat_x[19:10]), 32'd137);
      check("reset_x5", 32'(plat_x[59:50]), 32'd109);
      check("reset_x7", 32'(plat_x[79:70]), 32'd383);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      check("reset_step", 32'(scroll_step), 32'd0);
      check("reset_score", 32'(score), 32'd0);

      // Doodle below scroll line: no scroll
      run_frame(10'd300, 1'b1, 1, -1, 0);
      check_ys("noscroll");
      check("noscroll_x0", 32'(plat_x[9:0]), 32'd288);

      // Step 20 with platform 0 respawned at 0
      run_frame(10'd140, 1'b1, 17, -1, 20);
      exp_y = '{0, 420, 360, 300, 240, 180, 120, 60};
      check_ys("step20");
      check("respawn_x_range", 32'(plat_x[9:0] < 10'd576), 32'd1);
      check("step20_x1", 32'(plat_x[19:10]), 32'd137);

      // Clamped step
      run_frame(10'd10, 1'b1, 17, -1, 32);
      exp_y = '{32, 452, 392, 332, 272, 212, 152, 92};
      check_ys("step32");

      // Falling doodle: no scroll
      run_frame(10'd10, 1'b0, 1, -1, 0);
      check_ys("falling");
      check("overrun_clear", 32'(overrun), 32'd0);

      // Frame_Clk re-pulsed five cycles in
      run_frame(10'd140, 1'b1, 17, 4, 20);
      exp_y = '{52, 472, 412, 352, 292, 232, 172, 112};
      check_ys("overrun_frame");
      check("overrun_set", 32'(overrun), 32'd1);
      repeat (3) tick();
      check("overrun_sticky", 32'(overrun), 32'd1);

      // Reset in the middle of RECYCLE
      doodle_y  = 10'd140;
      doodle_up = 1'b1;
      Frame_Clk = 1'b1;
      tick();
      Frame_Clk = 1'b0;
      repeat (12) tick();
      check("mid_busy", 32'(busy), 32'd1);
      Reset_n = 1'b0;
      #1;
      exp_y = '{460, 400, 340, 280, 220, 160, 100, 40};
      check_ys("midreset");
      check("midreset_x0", 32'(plat_x[9:0]), 32'd288);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_overrun", 32'(overrun), 32'd0);
      check("midreset_step", 32'(scroll_step), 32'd0);
      check("midreset_score", 32'(score), 32'd0);
      exp_score = 0;
      tick();
      Reset_n = 1'b1;
      tick();

      // Two 20-pixel frames after reset
      run_frame(10'd140, 1'b1, 17, -1, 20);
      run_frame(10'd140, 1'b1, 17, -1, 20);
      exp_y = '{20, 440, 380, 320, 260, 200, 140, 80};
      check_ys("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
